// File: rtl/instruction_issue_pkg.sv
// Shared types for the ID->IX interface: execution pipe encoding, decoded
// instruction payload, and register-file geometry.
package instruction_issue_pkg;

    localparam int REG_WIDTH     = 5;
    localparam int NUM_REGS      = 32;
    localparam int NUM_EXE_PIPES = 4;

    localparam int EXE_PIPE_ID_ALU = 0;
    localparam int EXE_PIPE_ID_MUL = 1;
    localparam int EXE_PIPE_ID_DIV = 2;
    localparam int EXE_PIPE_ID_LSU = 3;

    // One-hot encoding: bit EXE_PIPE_ID_x selects pipe x, so it doubles as the ix_valid pattern.
    typedef enum logic [NUM_EXE_PIPES-1:0] {
        EXE_PIPE_INVALID = 4'b0000,
        EXE_PIPE_ALU     = 4'b0001,
        EXE_PIPE_MUL     = 4'b0010,
        EXE_PIPE_DIV     = 4'b0100,
        EXE_PIPE_LSU     = 4'b1000
    } exe_pipe_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0] a1;
        logic [REG_WIDTH-1:0] a2;
        logic [REG_WIDTH-1:0] rd;
        logic                 register_write;
        exe_pipe_e            exe_pipe;
        logic [2:0]           funct3;
        logic [31:0]          imm;
    } id_ix_inf_t;

endpackage

// File: rtl/instruction_issue_chk.sv
// Runtime checks for the issue stage: no dropped pushes, dispatch strobe one-hot.
module instruction_issue_chk #(
    parameter int NP = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          push_err_i,
    input logic [NP-1:0] ix_valid_i
);

    // Sampled every cycle outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!push_err_i) else $error("issue queue overflow: instruction dropped");
            assert ($onehot0(ix_valid_i)) else $error("ix_valid not one-hot");
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Generic synchronous FIFO with flush; a push while full is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o,
    output logic             push_err_o
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P   = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s  = push_i && ((count_q < DEPTH_C) || pop_i);
    assign pop_ok_s   = pop_i && (count_q != '0);
    assign push_err_o = push_i && !push_ok_s && !flush_i;
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Next-state for pointers and occupancy; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push_ok_s ? (wr_ptr_q + ONE_P) : wr_ptr_q;
            rd_ptr_d = pop_ok_s  ? (rd_ptr_q + ONE_P) : rd_ptr_q;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instruction_issue.sv
// Issue stage: in-order queue, register scoreboard and single-pipe dispatch
// of the queue head once operands are free and the target pipe is ready.
module instruction_issue
    import instruction_issue_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_do_branch,
    input  logic                     id_valid,
    input  id_ix_inf_t               id_ix_inf,
    input  logic                     wb_valid,
    input  logic [REG_WIDTH-1:0]     wb_rd,
    input  logic [NUM_EXE_PIPES-1:0] pipe_ready,
    output logic                     ix_stall,
    output logic [NUM_EXE_PIPES-1:0] ix_valid,
    output id_ix_inf_t               ix_inf
);

    localparam int              CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam int              IW        = $bits(id_ix_inf_t);
    localparam logic [CW-1:0]   STALL_LVL = CW'(QUEUE_DEPTH - STALL_MARGIN);

    logic                       push_s;
    logic                       dispatch_s;
    logic                       push_err_s;
    logic [IW-1:0]              head_bits_s;
    id_ix_inf_t                 head_s;
    logic [CW-1:0]              count_s;
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [NUM_EXE_PIPES-1:0]   ix_valid_q, ix_valid_d;
    id_ix_inf_t                 ix_inf_q;

    assign push_s = id_valid && !wb_do_branch && (id_ix_inf.exe_pipe != EXE_PIPE_INVALID);

    issue_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (IW)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (wb_do_branch),
        .push_i     (push_s),
        .data_i     (id_ix_inf),
        .pop_i      (dispatch_s),
        .data_o     (head_bits_s),
        .count_o    (count_s),
        .push_err_o (push_err_s)
    );

    assign head_s = id_ix_inf_t'(head_bits_s);

    // Dispatch needs a head with free sources, free destination, and its pipe ready.
    always_comb begin
        dispatch_s = (count_s != '0)
                  && !busy_q[head_s.a1]
                  && !busy_q[head_s.a2]
                  && !(head_s.register_write && busy_q[head_s.rd])
                  && (|(pipe_ready & head_s.exe_pipe));
        ix_valid_d = (dispatch_s && !wb_do_branch) ? head_s.exe_pipe : '0;
    end

    // Scoreboard: writeback clear first, then dispatch set; x0 is never busy.
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = !wb_do_branch
                     && ((dispatch_s && head_s.register_write && (head_s.rd == REG_WIDTH'(r)))
                      || (busy_q[r] && !(wb_valid && (wb_rd == REG_WIDTH'(r)))));
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            ix_valid_q <= '0;
        end else begin
            busy_q     <= busy_d;
            ix_valid_q <= ix_valid_d;
        end
    end

    // Dispatched payload; only meaningful while ix_valid is set.
    always_ff @(posedge clk) begin
        if (dispatch_s) begin
            ix_inf_q <= head_s;
        end
    end

    assign ix_valid = ix_valid_q;
    assign ix_inf   = ix_inf_q;
    assign ix_stall = (count_s >= STALL_LVL);

    instruction_issue_chk #(
        .NP (NUM_EXE_PIPES)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .push_err_i (push_err_s),
        .ix_valid_i (ix_valid_q)
    );

endmodule
